// File: rtl/nand_exerciser.sv
// On-chip truth-table checker for the dnand primitive: sweeps {a,b}, compares y, reports via busy/done/pass.
// Optional macro NAND_EXERCISER_FAULT_INJ_EN adds an `inject` input that forces a mismatch on SAMPLE cycles.
module nand_exerciser #(
  parameter int PASSES = 4,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef NAND_EXERCISER_FAULT_INJ_EN
  input  logic             inject,
`endif
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       vec_idx
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q;
  logic             a_q;
  logic             b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [1:0]       vec_q;
  logic [1:0]       vec_d;
  logic [SW-1:0]    settle_q;
  logic [PW-1:0]    pass_cnt_q;
  logic             mismatch;
  logic             last_vec;

  // Expected value is taken from the registered drive, which y has had a full cycle to follow.
  always_comb begin
    mismatch = (y != ~(a_q & b_q));
`ifdef NAND_EXERCISER_FAULT_INJ_EN
    mismatch = mismatch | inject;
`endif
    err_d = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
    vec_d    = vec_q + 2'd1;
    last_vec = (vec_q == 2'd3) && (pass_cnt_q == PW'(PASSES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      vec_q      <= 2'd0;
      settle_q   <= '0;
      pass_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            err_q      <= '0;
            pass_q     <= 1'b0;
            vec_q      <= 2'd0;
            pass_cnt_q <= '0;
            settle_q   <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (settle_q == SW'(SETTLE - 1)) begin
            settle_q <= '0;
            state_q  <= S_SAMPLE;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        S_SAMPLE: begin
          err_q <= err_d;
          vec_q <= vec_d;
          a_q   <= vec_d[1];
          b_q   <= vec_d[0];
          if (vec_q == 2'd3) begin
            pass_cnt_q <= pass_cnt_q + PW'(1);
          end
          // Final sample: verdict includes this cycle's compare result.
          if (last_vec) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            state_q <= S_DRIVE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec_idx = vec_q;

endmodule
